// File: rtl/tx_port_monitor_gen.sv
// tx_port_monitor_gen
// -------------------
// Watches the event/payload stream that tx_port_channel_gate leaves in its
// FIFO and turns it into transactions for the tx_port_buffer writer:
//   * an open marker (C_EVT_BEATS event beats) raises TXN with LEN/OFF/LAST
//     taken from the final open beat,
//   * after ACK, payload beats are forwarded on WR_DATA/WR_EN with WR_WORDS
//     giving the number of valid 32-bit words (the final beat is truncated
//     to exactly LEN words),
//   * surplus payload is dropped until a close marker (C_EVT_BEATS event
//     beats) returns the block to IDLE,
//   * a downstream TX_ERR abandons the payload and pulses ERR_ABORT.
//
// Handshakes:
//   EVT FIFO : EVT_DATA_RD_EN pops a beat when EVT_DATA_EMPTY=0; that beat is
//              presented on EVT_DATA in the following cycle (1-cycle latency).
//   Writer   : WR_EN is a one-cycle strobe with no backpressure; the monitor
//              itself throttles by stopping reads when WR_COUNT nears full.
//   TXN/ACK  : TXN stays high until sampled together with ACK=1; that cycle
//              is the transfer and TXN falls on the next edge.
//
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   EVT_DATA          FIFO beat; bit [C_DATA_WIDTH] flags an event beat whose
//                     bits [63:0] are {LEN[31:0], OFF[30:0], LAST}
//   EVT_DATA_EMPTY    FIFO empty
//   EVT_DATA_RD_EN    FIFO pop
//   WR_DATA/WR_EN     payload beat and its write strobe
//   WR_WORDS          valid words in WR_DATA (from the LSB) while WR_EN=1
//   WR_COUNT          downstream FIFO fill level
//   TXN/ACK           transaction parameters valid / consumed
//   LAST, OFF, LEN    transaction parameters
//   WORDS_RECVD       payload words forwarded in the current transaction
//   DONE              low only while payload is being forwarded
//   TX_ERR            downstream error
//   ERR_ABORT         one-cycle pulse when TX_ERR cut a transaction short
//   DBG_STATE         current FSM state encoding
module tx_port_monitor_gen #(
  parameter int C_DATA_WIDTH       = 256,
  parameter int C_FIFO_DEPTH       = 512,
  parameter int C_FIFO_HEADROOM    = 4,
  parameter int C_EVT_BEATS        = 2,
  parameter int C_FIFO_DEPTH_WIDTH = $clog2((2**$clog2(C_FIFO_DEPTH))+1),
  parameter int C_WCNT_WIDTH       = $clog2(C_DATA_WIDTH/32)+1
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [C_DATA_WIDTH:0]         EVT_DATA,
  input  logic                          EVT_DATA_EMPTY,
  output logic                          EVT_DATA_RD_EN,
  output logic [C_DATA_WIDTH-1:0]       WR_DATA,
  output logic                          WR_EN,
  output logic [C_WCNT_WIDTH-1:0]       WR_WORDS,
  input  logic [C_FIFO_DEPTH_WIDTH-1:0] WR_COUNT,
  output logic                          TXN,
  input  logic                          ACK,
  output logic                          LAST,
  output logic [30:0]                   OFF,
  output logic [31:0]                   LEN,
  output logic [31:0]                   WORDS_RECVD,
  output logic                          DONE,
  input  logic                          TX_ERR,
  output logic                          ERR_ABORT,
  output logic [2:0]                    DBG_STATE
);

  localparam int W = C_DATA_WIDTH / 32;
  localparam logic [31:0] W_U32 = 32'(W);
  localparam logic [C_WCNT_WIDTH-1:0] W_CNT = C_WCNT_WIDTH'(W);
  localparam logic [C_FIFO_DEPTH_WIDTH-1:0] AF_LEVEL =
    C_FIFO_DEPTH_WIDTH'(C_FIFO_DEPTH - C_FIFO_HEADROOM);
  localparam logic [2:0] EVT_LAST = 3'(C_EVT_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OPEN  = 3'd1,
    S_TXN   = 3'd2,
    S_READ  = 3'd3,
    S_DRAIN = 3'd4,
    S_CLOSE = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic       vld;        // EVT_DATA holds a beat popped last cycle
  logic       af;         // downstream almost full
  logic       err_q;      // TX_ERR delayed one cycle
  logic [2:0] ecnt, ecnt_nxt;

  logic        is_evt, evt_vld, pay_vld, open_final;
  logic [31:0] remaining;
  logic        last_beat;
  logic [C_WCNT_WIDTH-1:0] beat_words;
  logic        capture, words_clr, wr_en_c, abort_c;

  assign is_evt  = EVT_DATA[C_DATA_WIDTH];
  assign evt_vld = vld & is_evt;
  assign pay_vld = vld & ~is_evt;

  // The beat that completes the open marker must not be followed by a pop:
  // the FSM parks in TXN and a beat arriving there would be lost.
  assign open_final = evt_vld &&
                      (((state == S_IDLE) && (C_EVT_BEATS == 1)) ||
                       ((state == S_OPEN) && (ecnt == EVT_LAST)));

  assign remaining  = LEN - WORDS_RECVD;
  assign last_beat  = (remaining <= W_U32);
  assign beat_words = last_beat ? remaining[C_WCNT_WIDTH-1:0] : W_CNT;

  // Gated with RST_N so no pop can happen while reset is held.
  assign EVT_DATA_RD_EN = RST_N && !EVT_DATA_EMPTY && (state != S_TXN) &&
                          !af && !open_final;

  assign WR_DATA   = EVT_DATA[C_DATA_WIDTH-1:0];
  assign WR_EN     = wr_en_c;
  assign WR_WORDS  = beat_words;
  assign TXN       = (state == S_TXN);
  assign DONE      = (state != S_READ);
  assign DBG_STATE = state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ecnt_nxt  = ecnt;
    capture   = 1'b0;
    words_clr = 1'b0;
    wr_en_c   = 1'b0;
    abort_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (evt_vld) begin
          if (C_EVT_BEATS == 1) begin
            state_nxt = S_TXN;
            ecnt_nxt  = 3'd0;
            capture   = 1'b1;
          end else begin
            state_nxt = S_OPEN;
            ecnt_nxt  = 3'd1;
          end
        end
      end
      S_OPEN: begin
        if (evt_vld) begin
          if (ecnt == EVT_LAST) begin
            state_nxt = S_TXN;
            ecnt_nxt  = 3'd0;
            capture   = 1'b1;
          end else begin
            ecnt_nxt = ecnt + 3'd1;
          end
        end
      end
      S_TXN: begin
        if (ACK) begin
          words_clr = 1'b1;
          state_nxt = (LEN == 32'd0) ? S_DRAIN : S_READ;
        end
      end
      S_READ: begin
        // Event beats win over a pending error; an error cycle drops any
        // payload beat arriving with it since the transaction is over.
        if (evt_vld) begin
          if (C_EVT_BEATS == 1) begin
            state_nxt = S_IDLE;
            ecnt_nxt  = 3'd0;
          end else begin
            state_nxt = S_CLOSE;
            ecnt_nxt  = 3'd1;
          end
        end else if (err_q) begin
          state_nxt = S_DRAIN;
          abort_c   = 1'b1;
        end else if (pay_vld) begin
          wr_en_c = 1'b1;
          if (last_beat) begin
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (evt_vld) begin
          if (C_EVT_BEATS == 1) begin
            state_nxt = S_IDLE;
            ecnt_nxt  = 3'd0;
          end else begin
            state_nxt = S_CLOSE;
            ecnt_nxt  = 3'd1;
          end
        end
      end
      S_CLOSE: begin
        if (evt_vld) begin
          if (ecnt == EVT_LAST) begin
            state_nxt = S_IDLE;
            ecnt_nxt  = 3'd0;
          end else begin
            ecnt_nxt = ecnt + 3'd1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        ecnt_nxt  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld         <= 1'b0;
      af          <= 1'b0;
      err_q       <= 1'b0;
      ecnt        <= 3'd0;
      LEN         <= 32'd0;
      OFF         <= 31'd0;
      LAST        <= 1'b0;
      WORDS_RECVD <= 32'd0;
      ERR_ABORT   <= 1'b0;
    end else begin
      vld       <= EVT_DATA_RD_EN;
      af        <= (WR_COUNT >= AF_LEVEL);
      err_q     <= TX_ERR;
      ecnt      <= ecnt_nxt;
      ERR_ABORT <= abort_c;
      if (capture) begin
        {LEN, OFF, LAST} <= EVT_DATA[63:0];
      end
      if (words_clr) begin
        WORDS_RECVD <= 32'd0;
      end else if (wr_en_c) begin
        WORDS_RECVD <= WORDS_RECVD + 32'(beat_words);
      end
    end
  end

endmodule
